// File: rtl/pipelined_core.sv
// rtl/pipelined_core.sv - 4-stage pipelined core with forwarding, branch flush, dmem stall and HALT
module pipelined_core #(
    parameter int DATA_W  = 16,
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [23:0]        imem_data,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               dmem_we,
    output logic               dmem_re,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ready,
    output logic               retire_valid,
    output logic [IMEM_AW-1:0] retire_pc,
    output logic               halted
);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_J    = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd15;

    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic               halted_q;
    logic [DATA_W-1:0]  rf_q [16];

    logic               id_valid_q;
    logic [23:0]        id_instr_q;
    logic [IMEM_AW-1:0] id_pc_q;

    logic               ex_valid_q;
    logic [3:0]         ex_op_q, ex_rd_q, ex_rs_q, ex_rt_q;
    logic [7:0]         ex_imm_q;
    logic [DATA_W-1:0]  ex_a_q, ex_b_q;
    logic [IMEM_AW-1:0] ex_pc_q, ex_jt_q;

    logic               mw_valid_q;
    logic [3:0]         mw_op_q, mw_rd_q;
    logic [DATA_W-1:0]  mw_res_q, mw_st_q;
    logic [IMEM_AW-1:0] mw_pc_q;

    logic               mw_mem, stall, mw_writes, mw_halt, wb_en, taken;
    logic [DATA_W-1:0]  wb_data, id_a, id_b, ex_a, ex_b, ex_simm, ex_res;
    logic [IMEM_AW-1:0] br_target;

    // MW stage: memory handshake, writeback value and halt detection
    always_comb begin
        mw_mem    = mw_valid_q && (mw_op_q == OP_LW || mw_op_q == OP_SW);
        stall     = mw_mem && !dmem_ready;
        mw_writes = mw_valid_q && (mw_op_q >= OP_ADD) && (mw_op_q <= OP_LW);
        mw_halt   = mw_valid_q && (mw_op_q == OP_HALT);
        wb_data   = (mw_op_q == OP_LW) ? dmem_rdata : mw_res_q;
        wb_en     = mw_writes && (mw_rd_q != 4'd0) && !stall;
    end

    // ID register read; the value being written back this cycle passes straight through
    always_comb begin
        id_a = rf_q[id_instr_q[15:12]];
        id_b = rf_q[id_instr_q[11:8]];
        if (wb_en && mw_rd_q == id_instr_q[15:12]) id_a = wb_data;
        if (wb_en && mw_rd_q == id_instr_q[11:8])  id_b = wb_data;
    end

    // EX: forward from MW over the ID-read operands, ALU, branch resolution and next PC
    always_comb begin
        ex_a    = (mw_writes && mw_rd_q != 4'd0 && mw_rd_q == ex_rs_q) ? wb_data : ex_a_q;
        ex_b    = (mw_writes && mw_rd_q != 4'd0 && mw_rd_q == ex_rt_q) ? wb_data : ex_b_q;
        ex_simm = DATA_W'($signed(ex_imm_q));
        case (ex_op_q)
            OP_ADD:                ex_res = ex_a + ex_b;
            OP_SUB:                ex_res = ex_a - ex_b;
            OP_AND:                ex_res = ex_a & ex_b;
            OP_OR:                 ex_res = ex_a | ex_b;
            OP_SLT:                ex_res = ($signed(ex_a) < $signed(ex_b)) ? DATA_W'(1) : '0;
            OP_ADDI, OP_LW, OP_SW: ex_res = ex_a + ex_simm;
            default:               ex_res = '0;
        endcase
        taken     = ex_valid_q && ((ex_op_q == OP_BEQ && ex_a == ex_b) || ex_op_q == OP_J);
        br_target = (ex_op_q == OP_J) ? ex_jt_q
                                      : ex_pc_q + IMEM_AW'(1) + IMEM_AW'($signed(ex_imm_q));
        pc_d      = taken ? br_target : pc_q + IMEM_AW'(1);
    end

    // Pipeline advance; a memory stall or the halted state freezes all state
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            halted_q   <= 1'b0;
            id_valid_q <= 1'b0;
            ex_valid_q <= 1'b0;
            mw_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
            ex_op_q    <= '0;
            ex_rd_q    <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_imm_q   <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_pc_q    <= '0;
            ex_jt_q    <= '0;
            mw_op_q    <= '0;
            mw_rd_q    <= '0;
            mw_res_q   <= '0;
            mw_st_q    <= '0;
            mw_pc_q    <= '0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else if (!halted_q && !stall) begin
            if (mw_halt) begin
                halted_q   <= 1'b1;
                id_valid_q <= 1'b0;
                ex_valid_q <= 1'b0;
                mw_valid_q <= 1'b0;
            end else begin
                pc_q       <= pc_d;
                id_valid_q <= !taken;
                ex_valid_q <= id_valid_q && !taken;
                mw_valid_q <= ex_valid_q;
                id_instr_q <= imem_data;
                id_pc_q    <= pc_q;
                ex_op_q    <= id_instr_q[23:20];
                ex_rd_q    <= id_instr_q[19:16];
                ex_rs_q    <= id_instr_q[15:12];
                ex_rt_q    <= id_instr_q[11:8];
                ex_imm_q   <= id_instr_q[7:0];
                ex_jt_q    <= id_instr_q[IMEM_AW-1:0];
                ex_a_q     <= id_a;
                ex_b_q     <= id_b;
                ex_pc_q    <= id_pc_q;
                mw_op_q    <= ex_op_q;
                mw_rd_q    <= ex_rd_q;
                mw_res_q   <= ex_res;
                mw_st_q    <= ex_b;
                mw_pc_q    <= ex_pc_q;
                if (wb_en) rf_q[mw_rd_q] <= wb_data;
            end
        end
    end

    assign imem_addr    = pc_q;
    assign dmem_addr    = DMEM_AW'(mw_res_q);
    assign dmem_wdata   = mw_st_q;
    assign dmem_we      = !reset && !halted_q && mw_valid_q && (mw_op_q == OP_SW);
    assign dmem_re      = !reset && !halted_q && mw_valid_q && (mw_op_q == OP_LW);
    assign retire_valid = !reset && !halted_q && mw_valid_q && !stall;
    assign retire_pc    = mw_pc_q;
    assign halted       = halted_q;

endmodule
